// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and helpers.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // True for either shift direction; both advance the per-word shift count.
    function automatic logic is_shift(input mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control, data and status bundle of the universal shift register.
interface univ_shift_reg_if
    import univ_shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             en;
    mode_e            mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pout;
    logic             sout_r;
    logic             sout_l;
    logic [CNT_W-1:0] cnt;
    logic             word_done;

    modport master (
        output en, mode, sin_r, sin_l, pin,
        input  pout, sout_r, sout_l, cnt, word_done
    );

    modport slave (
        input  en, mode, sin_r, sin_l, pin,
        output pout, sout_r, sout_l, cnt, word_done
    );

endinterface

// File: rtl/univ_shift_reg_shift_cell.sv
// One register bit: 4:1 mux (hold / left neighbour / right neighbour / parallel bit)
// feeding an asynchronously reset flop.
module shift_cell
    import univ_shift_reg_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_e mode,
    input  logic  from_left,
    input  logic  from_right,
    input  logic  pin_bit,
    output logic  q
);

    logic d_c;

    always_comb begin
        d_c = q;
        case (mode)
            MODE_HOLD: d_c = q;
            MODE_SHR:  d_c = from_left;
            MODE_SHL:  d_c = from_right;
            MODE_LOAD: d_c = pin_bit;
            default:   d_c = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_BIT;
        end else if (en) begin
            q <= d_c;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: bit-cell datapath plus per-word shift counter and
// a one-cycle word_done pulse after the WIDTH-th shift.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    univ_shift_reg_if.slave   bus
);

    localparam int unsigned      CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;
    logic [CNT_W-1:0] cnt_q;
    logic             word_done_q;
    logic             shift_c;
    logic             load_c;
    logic             wrap_c;

    // Neighbour each bit takes from on a right / left shift.
    assign shr_src = {bus.sin_r, q[WIDTH-1:1]};
    assign shl_src = {q[WIDTH-2:0], bus.sin_l};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_cell #(
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .en         (bus.en),
            .mode       (bus.mode),
            .from_left  (shr_src[i]),
            .from_right (shl_src[i]),
            .pin_bit    (bus.pin[i]),
            .q          (q[i])
        );
    end

    assign shift_c = bus.en && is_shift(bus.mode);
    assign load_c  = bus.en && (bus.mode == MODE_LOAD);
    assign wrap_c  = shift_c && (cnt_q == LAST);

    // A load always wins over the wrap and never raises word_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            word_done_q <= wrap_c;
            if (load_c || wrap_c) begin
                cnt_q <= '0;
            end else if (shift_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pout      = q;
    assign bus.sout_r    = q[0];
    assign bus.sout_l    = q[WIDTH-1];
    assign bus.cnt       = cnt_q;
    assign bus.word_done = word_done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=0).
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    typedef struct packed {
        logic [7:0] pout;
        logic [3:0] cnt;
        logic       wd;
        logic       sl;
        logic       sr;
    } obs_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    obs_t       sb[$];
    obs_t       exp_o;
    obs_t       got;
    logic [7:0] m_pout;
    int         m_cnt;
    logic       m_wd;

    univ_shift_reg_if #(.WIDTH(8)) bus ();

    univ_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        return {bus.pout, bus.cnt, bus.word_done, bus.sout_l, bus.sout_r};
    endfunction

    function automatic obs_t mk(input logic [7:0] p, input int c, input logic wd);
        return {p, 4'(c), wd, p[7], p[0]};
    endfunction

    task automatic model_reset();
        m_pout = 8'h00;
        m_cnt  = 0;
        m_wd   = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle, push the model's expected post-edge state, advance past the edge.
    task automatic drive_cycle(input logic en, input mode_e mode, input logic sr,
                               input logic sl, input logic [7:0] pin);
        bus.en    = en;
        bus.mode  = mode;
        bus.sin_r = sr;
        bus.sin_l = sl;
        bus.pin   = pin;
        m_wd = en && (mode == MODE_SHR || mode == MODE_SHL) && (m_cnt == 7);
        if (en) begin
            case (mode)
                MODE_SHR:  begin m_pout = {sr, m_pout[7:1]}; m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1; end
                MODE_SHL:  begin m_pout = {m_pout[6:0], sl}; m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1; end
                MODE_LOAD: begin m_pout = pin; m_cnt = 0; end
                default:   ;
            endcase
        end
        sb.push_back(mk(m_pout, m_cnt, m_wd));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1; bus.mode = MODE_LOAD; bus.pin = 8'hFF;
        bus.sin_r = 1'b1; bus.sin_l = 1'b1;
        #12;
        got = observe();
        n_tests++;
        if (got !== mk(8'h00, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_hold: got %h required %h", got, mk(8'h00, 0, 1'b0));
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_load();
        drive_cycle(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5);
        exp_o = sb.pop_front(); got = observe();
        n_tests++;
        if (got !== exp_o || got !== mk(8'hA5, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL load_a5: got %h required %h", got, mk(8'hA5, 0, 1'b0));
        end
    endtask

    task automatic test_shr_word();
        logic [7:0] seq;
        int pulses;
        seq = 8'hA5;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (bus.sout_r !== seq[i]) begin
                n_fail++;
                $display("FAIL shr_sout_r%0d: got %b required %b", i, bus.sout_r, seq[i]);
            end
            drive_cycle(1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
            exp_o = sb.pop_front(); got = observe();
            if (got.wd) pulses++;
            n_tests++;
            if (got !== exp_o) begin
                n_fail++;
                $display("FAIL shr_step%0d: got %h required %h", i, got, exp_o);
            end
        end
        n_tests++;
        if (got !== mk(8'h00, 0, 1'b1) || pulses != 1) begin
            n_fail++;
            $display("FAIL shr_wrap: got %h pulses %0d required %h pulses 1", got, pulses, mk(8'h00, 0, 1'b1));
        end
        drive_cycle(1'b1, MODE_HOLD, 1'b1, 1'b1, 8'hFF);
        exp_o = sb.pop_front(); got = observe();
        n_tests++;
        if (got !== exp_o || got.wd !== 1'b0) begin
            n_fail++;
            $display("FAIL shr_pulse_width: got %h required %h", got, exp_o);
        end
    endtask

    task automatic test_shl();
        drive_cycle(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h01);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, MODE_SHL, 1'b0, 1'b1, 8'h00);
            exp_o = sb.pop_front(); got = observe();
            n_tests++;
            if (got !== exp_o || got.wd !== 1'b0) begin
                n_fail++;
                $display("FAIL shl_step%0d: got %h required %h", i, got, exp_o);
            end
        end
        n_tests++;
        if (got !== mk(8'h0F, 3, 1'b0)) begin
            n_fail++;
            $display("FAIL shl_final: got %h required %h", got, mk(8'h0F, 3, 1'b0));
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, MODE_SHR, 1'b1, 1'b1, 8'($urandom));
            exp_o = sb.pop_front(); got = observe();
            n_tests++;
            if (got !== exp_o || got !== mk(8'h0F, 3, 1'b0)) begin
                n_fail++;
                $display("FAIL en_gate%0d: got %h required %h", i, got, mk(8'h0F, 3, 1'b0));
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, MODE_HOLD, 1'b1, 1'b1, 8'hFF);
            exp_o = sb.pop_front(); got = observe();
            n_tests++;
            if (got !== exp_o || got !== mk(8'h0F, 3, 1'b0)) begin
                n_fail++;
                $display("FAIL hold%0d: got %h required %h", i, got, mk(8'h0F, 3, 1'b0));
            end
        end
    endtask

    task automatic test_load_at_wrap();
        drive_cycle(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
        void'(sb.pop_front());
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1'b1, (i % 2 == 0) ? MODE_SHR : MODE_SHL, i[0], ~i[0], 8'h00);
            exp_o = sb.pop_front(); got = observe();
            n_tests++;
            if (got !== exp_o) begin
                n_fail++;
                $display("FAIL mixed_step%0d: got %h required %h", i, got, exp_o);
            end
        end
        n_tests++;
        if (bus.cnt !== 4'd7) begin
            n_fail++;
            $display("FAIL mixed_cnt7: got %0d required 7", bus.cnt);
        end
        drive_cycle(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hC3);
        exp_o = sb.pop_front(); got = observe();
        n_tests++;
        if (got !== exp_o || got !== mk(8'hC3, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL load_at_wrap: got %h required %h", got, mk(8'hC3, 0, 1'b0));
        end
        drive_cycle(1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00);
        exp_o = sb.pop_front(); got = observe();
        n_tests++;
        if (got !== exp_o || got.wd !== 1'b0) begin
            n_fail++;
            $display("FAIL load_no_pulse: got %h required %h", got, exp_o);
        end
    endtask

    task automatic test_wrap_then_disable();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, MODE_SHL, 1'b0, 1'b1, 8'h00);
            void'(sb.pop_front());
        end
        n_tests++;
        if (bus.word_done !== 1'b1 || bus.cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_pulse: got wd %b cnt %0d required wd 1 cnt 0", bus.word_done, bus.cnt);
        end
        drive_cycle(1'b0, MODE_SHL, 1'b0, 1'b1, 8'h00);
        exp_o = sb.pop_front(); got = observe();
        n_tests++;
        if (got !== exp_o || got.wd !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_after_disable: got %h required %h", got, exp_o);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        drive_cycle(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h5A);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
            void'(sb.pop_front());
        end
        #2 rst = 1'b1;
        #1;
        got = observe();
        n_tests++;
        if (got !== mk(8'h00, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL async_reset: got %h required %h", got, mk(8'h00, 0, 1'b0));
        end
        #2 rst = 1'b0;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1'b1, (i < 8) ? MODE_SHL : MODE_HOLD, 1'($urandom), 1'($urandom), 8'h00);
            exp_o = sb.pop_front(); got = observe();
            if (got.wd) pulses++;
            n_tests++;
            if (got !== exp_o) begin
                n_fail++;
                $display("FAIL post_reset_step%0d: got %h required %h", i, got, exp_o);
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL post_reset_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive_cycle(($urandom_range(0, 7) != 0), mode_e'(2'($urandom_range(0, 3))),
                        1'($urandom), 1'($urandom), 8'($urandom));
            exp_o = sb.pop_front(); got = observe();
            n_tests++;
            if (got !== exp_o) begin
                n_fail++;
                $display("FAIL random%0d: got %h required %h", i, got, exp_o);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_load();
        test_shr_word();
        test_shl();
        test_enable();
        test_load_at_wrap();
        test_wrap_then_disable();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; the legal range SHALL be WIDTH >= 2.
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into the register on reset.
REQ-003 Port clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  clock enable; when low, all state SHALL hold.
REQ-006 Port mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port sin_r  input  1  serial data entering the MSB on a right shift.
REQ-008 Port sin_l  input  1  serial data entering the LSB on a left shift.
REQ-009 Port pin  input  WIDTH  parallel load data.
REQ-010 Port pout  output  WIDTH  current register contents.
REQ-011 Port sout_r  output  1  combinational copy of pout[0].
REQ-012 Port sout_l  output  1  combinational copy of pout[WIDTH-1].
REQ-013 Port cnt  output  $clog2(WIDTH+1)  number of shifts since the last load, wrap or reset.
REQ-014 Port word_done  output  1  registered one-cycle pulse after the WIDTH-th shift of a word.

Function
REQ-015 With en=1 and mode=00, pout and cnt SHALL hold, and word_done SHALL be 0 on the next cycle.
REQ-016 With en=1 and mode=01, pout SHALL become {sin_r, pout[WIDTH-1:1]} on the next edge.
REQ-017 With en=1 and mode=10, pout SHALL become {pout[WIDTH-2:0], sin_l} on the next edge.
REQ-018 With en=1 and mode=11, pout SHALL become pin and cnt SHALL become 0 on the next edge.
REQ-019 Each right or left shift SHALL increment cnt by 1.
REQ-020 A shift taken while cnt == WIDTH-1 SHALL set cnt to 0 and set word_done to 1 for exactly the following cycle.
REQ-021 word_done SHALL be 0 in every cycle that does not immediately follow a wrapping shift, including every cycle after a cycle with en=0.
REQ-022 Mixing right and left shifts within one word SHALL count toward the same cnt.
REQ-023 A load SHALL clear cnt with no word_done pulse, even when cnt == WIDTH-1.
REQ-024 When en=0, mode, pin and the serial inputs SHALL have no effect.
REQ-025 Latency from the clock edge to a change on pout, cnt or word_done SHALL be one cycle; sout_r and sout_l SHALL follow pout combinationally.

Reset
REQ-026 While rst=1, independent of clk: pout SHALL equal RESET_VAL, cnt SHALL be 0 and word_done SHALL be 0.
REQ-027 Reset asserted mid-word SHALL discard the partial count.
REQ-028 The first edge after rst is released SHALL perform normal operation per REQ-015 to REQ-020.

Structure
REQ-029 Mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) SHALL be defined as constants in a shared package, univ_shift_reg_pkg.
REQ-030 The datapath SHALL be built from WIDTH instances of one sub-module, shift_cell.
REQ-031 Each shift_cell SHALL contain a 4:1 mux (hold, left neighbour, right neighbour, parallel bit) feeding one asynchronously reset flop.
REQ-032 The counter and the word_done logic SHALL live in the top level.

Verification (WIDTH=8, RESET_VAL=0)
REQ-033 Scenario 1, load: pulse rst, then load pin=8'hA5 -> pout=8'hA5, cnt=0, sout_l=1, sout_r=1.
REQ-034 Scenario 2, right shift of a full word: from 8'hA5, 8 right shifts with sin_r=0.
- sout_r sequence before each edge SHALL be 1,0,1,0,0,1,0,1.
- After the 8th edge: pout=8'h00, cnt=0, and word_done=1 for one cycle only.
REQ-035 Scenario 3, left shifts: load 8'h01, then 3 left shifts with sin_l=1 -> pout=8'h0F, cnt=3, word_done stays 0.
REQ-036 Scenario 4, enable gating: with cnt=3, hold en=0 for 5 cycles with mode=01 -> pout and cnt unchanged; with en=1 and mode=00 -> also unchanged.
REQ-037 Scenario 5, load at wrap point: with cnt=7, apply a load -> cnt=0 and no word_done pulse.
REQ-038 Scenario 6, asynchronous reset: assert rst mid-word between clock edges.
- pout SHALL become 8'h00 and cnt 0 before the next edge.
- After release, 8 further shifts SHALL produce exactly one word_done pulse.
